// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core fetch front end.
// Holds word_t, redirect kinds, fetch FSM states and the queued entry type.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        PC_SEQ = 3'd0,
        PC_BR  = 3'd1,
        PC_J   = 3'd2,
        PC_JR  = 3'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    // Reserved codes 4..7 fall through to the sequential target.
    function automatic word_t calc_target(
        input logic [2:0]  src,
        input word_t       npc,
        input logic [15:0] imm16,
        input logic [25:0] jaddr,
        input word_t       reg31
    );
        word_t t;
        case (src)
            PC_BR:   t = npc + {{14{imm16[15]}}, imm16, 2'b00};
            PC_J:    t = {npc[31:28], jaddr, 2'b00};
            PC_JR:   t = reg31;
            default: t = npc;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instruction_prefetch_unit_fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between icache and decode.
// Ports: push/entry in, pop, flush, full/empty/count status, head out (0 when empty).
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Flush only rewinds the pointers; stale storage is never visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= entry;
    end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Fetch front end: owns the PC, issues icache reads, queues fetched words for decode.
// Ports: CLK/nRST, redirect (PCSrc encoding), halt, icache req/resp, decode valid/ready head.
module instruction_prefetch_unit
    import cpu_types_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        redirect_en,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] redirect_npc,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  logic [31:0] reg31,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  fetch_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    fetch_state_t state;
    word_t        fetch_pc;
    word_t        target;
    logic         redir;
    logic         push;
    logic         pop;
    logic         q_full;
    logic         q_empty;
    logic [AW:0]  q_count;
    fetch_entry_t head;

    // A halted unit ignores redirects entirely, including the valid mask.
    assign redir       = redirect_en && (state != HALTED);
    assign target      = calc_target(PCSrc, redirect_npc, imm16, jaddr, reg31);
    assign push        = (state == FETCH) && ihit && !redir && !q_full;
    assign instr_valid = !q_empty && !redir;
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign imemaddr    = fetch_pc;
    assign fetch_state = state;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (push),
        .entry ('{pc: fetch_pc, instr: imemload}),
        .pop   (pop),
        .flush (redir),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (head)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= FETCH;
            fetch_pc <= PC_RESET;
            imemREN  <= 1'b1;
        end else begin
            case (state)
                FETCH, FULL: begin
                    if (redir) begin
                        fetch_pc <= target;
                        state    <= halt ? HALTED : FETCH;
                        imemREN  <= !halt;
                    end else begin
                        if (push) fetch_pc <= fetch_pc + 32'd4;
                        if (halt) begin
                            state   <= HALTED;
                            imemREN <= 1'b0;
                        end else if (push && !pop && q_count == LAST) begin
                            state   <= FULL;
                            imemREN <= 1'b0;
                        end else if (state == FULL && pop) begin
                            state   <= FETCH;
                            imemREN <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= HALTED;
                    imemREN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Scoreboard bench for instruction_prefetch_unit.
// Two instances: PC_RESET=0x100 for the main flow, 0xFFFF_FFFC for wrap.
module tb_instruction_prefetch_unit;

    logic        CLK = 0;
    logic        nRST;
    logic        redirect_en;
    logic [2:0]  PCSrc;
    logic [31:0] redirect_npc;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] reg31;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        instr_ready;

    logic        imemREN, instr_valid;
    logic [31:0] imemaddr, instr, instr_pc;
    logic [1:0]  fetch_state;

    logic        w_ren, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [1:0]  w_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];
    logic [31:0] pc;

    always #5 CLK = ~CLK;

    instruction_prefetch_unit #(.DEPTH(4), .PC_RESET(32'h100)) dut (
        .CLK(CLK), .nRST(nRST), .redirect_en(redirect_en), .PCSrc(PCSrc),
        .redirect_npc(redirect_npc), .imm16(imm16), .jaddr(jaddr),
        .reg31(reg31), .halt(halt), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .fetch_state(fetch_state)
    );

    instruction_prefetch_unit #(.DEPTH(4), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .nRST(nRST), .redirect_en(redirect_en), .PCSrc(PCSrc),
        .redirect_npc(redirect_npc), .imm16(imm16), .jaddr(jaddr),
        .reg31(reg31), .halt(halt), .imemREN(w_ren), .imemaddr(w_addr),
        .ihit(ihit), .imemload(imemload), .instr_valid(w_valid),
        .instr_ready(instr_ready), .instr(w_instr), .instr_pc(w_pc),
        .fetch_state(w_state)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Model the icache returning the word at the modelled PC and record it.
    task automatic hit_push();
        imemload = word_of(pc);
        ihit = 1;
        sb.push_back({pc, word_of(pc)});
        step();
        ihit = 0;
        pc = pc + 32'd4;
    endtask

    task automatic do_redirect(input logic [2:0] src, input logic [31:0] npc,
                               input logic [15:0] imm, input logic [25:0] ja,
                               input logic [31:0] r31, input logic [31:0] exp,
                               input string tag);
        redirect_en = 1; PCSrc = src; redirect_npc = npc;
        imm16 = imm; jaddr = ja; reg31 = r31;
        sb.delete();
        step();
        redirect_en = 0;
        chk(tag, imemaddr, exp);
        pc = exp;
    endtask

    always @(negedge CLK) begin
        if (nRST && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow got pc %h exp none", instr_pc);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("head_pc", instr_pc, e[63:32]);
                chk("head_instr", instr, e[31:0]);
            end
        end
    end

    initial begin
        nRST = 0; redirect_en = 0; PCSrc = 0; redirect_npc = 0;
        imm16 = 0; jaddr = 0; reg31 = 0; halt = 0; ihit = 0;
        imemload = 0; instr_ready = 0;
        step(); step();
        nRST = 1;

        chk("rst_ren", 32'(imemREN), 1);
        chk("rst_addr", imemaddr, 32'h100);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_state", 32'(fetch_state), 0);
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);

        // Streaming with continuous ready.
        pc = 32'h100;
        instr_ready = 1;
        hit_push();
        chk("wrap_next_addr", w_addr, 32'h0);
        chk("latency_valid", 32'(instr_valid), 1);
        chk("latency_pc", instr_pc, 32'h100);
        hit_push();
        hit_push();
        step(); step();
        chk("stream_drain", sb.size(), 0);
        chk("stream_addr", imemaddr, 32'h10C);

        // Fill to FULL with decode stalled.
        instr_ready = 0;
        for (int i = 0; i < 4; i++) hit_push();
        chk("full_state", 32'(fetch_state), 1);
        chk("full_ren", 32'(imemREN), 0);
        ihit = 1;
        step();
        ihit = 0;
        chk("full_hold_addr", imemaddr, 32'h11C);
        chk("full_hold_state", 32'(fetch_state), 1);
        instr_ready = 1;
        step();
        instr_ready = 0;
        chk("refetch_state", 32'(fetch_state), 0);
        chk("refetch_ren", 32'(imemREN), 1);
        chk("refetch_addr", imemaddr, 32'h11C);

        // Branch redirect with a same-cycle hit that must be dropped.
        instr_ready = 1;
        ihit = 1;
        imemload = 32'hDEAD_BEEF;
        redirect_en = 1; PCSrc = 3'd1; redirect_npc = 32'h200; imm16 = 16'hFFFE;
        #1;
        chk("redir_valid_mask", 32'(instr_valid), 0);
        sb.delete();
        step();
        redirect_en = 0; ihit = 0;
        chk("br_addr", imemaddr, 32'h1F8);
        chk("br_empty", 32'(instr_valid), 0);
        pc = 32'h1F8;
        hit_push();
        step();
        chk("br_drain", sb.size(), 0);

        do_redirect(3'd2, 32'h9000_0000, 16'h0, 26'h40, 32'h0, 32'h9000_0100, "j_addr");
        do_redirect(3'd3, 32'h0, 16'h0, 26'h0, 32'h3C, 32'h3C, "jr_addr");
        do_redirect(3'd1, 32'h1000, 16'h0010, 26'h0, 32'h0, 32'h1040, "brpos_addr");
        do_redirect(3'd5, 32'h400, 16'h1234, 26'h3FF, 32'h77, 32'h400, "rsv_addr");

        // Halt with two queued entries; they must still drain.
        instr_ready = 0;
        hit_push();
        hit_push();
        halt = 1;
        step();
        halt = 0;
        chk("halt_ren", 32'(imemREN), 0);
        chk("halt_state", 32'(fetch_state), 2);
        instr_ready = 1;
        step(); step(); step();
        chk("halt_drain", sb.size(), 0);
        chk("halt_empty", 32'(instr_valid), 0);
        redirect_en = 1; PCSrc = 3'd3; reg31 = 32'h800;
        step();
        redirect_en = 0;
        chk("halt_redir_addr", imemaddr, 32'h408);
        chk("halt_redir_state", 32'(fetch_state), 2);

        nRST = 0;
        step();
        nRST = 1;
        chk("rerst_addr", imemaddr, 32'h100);
        chk("rerst_state", 32'(fetch_state), 0);
        chk("rerst_ren", 32'(imemREN), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_unit.md
# instruction_prefetch_unit

Parametrised fetch front end for the pipelined MIPS core: it owns the PC, issues instruction reads to the icache, and buffers fetched words with their PCs in a DEPTH-entry queue feeding decode over a valid/ready handshake. Later stages redirect it (branch, jump, jr) through the same PCSrc/imm16/jaddr/reg31 encoding used by the existing fetch unit. A redirect flushes the queue and abandons any outstanding fetch. It also supports a halt mode that stops fetching while letting the queue drain.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- PC_RESET, 32'h0000_0000: PC after reset
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  synchronous active-low reset
- redirect_en  in  1  redirect request this cycle
- PCSrc  in  3  redirect kind (pcsrc_t)
- redirect_npc  in  32  PC+4 of the redirecting instruction
- imm16  in  16  branch offset, words
- jaddr  in  26  jump target field
- reg31  in  32  jr target register value
- halt  in  1  stop fetching (sticky until reset)
- imemREN  out  1  icache read request
- imemaddr  out  32  icache read address
- ihit  in  1  icache returns imemload this cycle
- imemload  in  32  fetched instruction
- instr_valid  out  1  queue head valid for decode
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  32  head PC
- fetch_state  out  2  current FSM state, for debug

## Operation
- Reset (nRST low at edge): fetch_pc=PC_RESET, queue empty, state=FETCH. Outputs after reset: imemREN=1, imemaddr=PC_RESET, instr_valid=0, instr=0, instr_pc=0.
- FSM states: FETCH, FULL, HALTED.
  - FETCH: imemREN=1, imemaddr=fetch_pc. On ihit, push {fetch_pc, imemload} and set fetch_pc+=4. If the push makes the count DEPTH with no pop, go to FULL.
  - FULL: imemREN=0. Return to FETCH on any pop.
  - HALTED: imemREN=0, absorbing until reset. The queue still drains to decode.
- halt=1 in FETCH or FULL moves to HALTED next edge. An ihit in that same cycle is still accepted.
- Redirect target by PCSrc:
  - PC_SEQ(0): redirect_npc
  - PC_BR(1): redirect_npc + sign_extend(imm16)<<2
  - PC_J(2): {redirect_npc[31:28], jaddr, 2'b00}
  - PC_JR(3): reg31
  - codes 4–7 are reserved and behave as PC_SEQ
  - All sums are modulo 2^32.
- Redirect in FETCH or FULL:
  - fetch_pc=target; queue count=0; state=FETCH.
  - An ihit in the same cycle is discarded.
  - instr_valid is forced 0 in that cycle, so no transfer occurs.
  - Redirect has priority over push, pop and halt, except that halt=1 with redirect in the same cycle loads the target and then enters HALTED.
- Redirect in HALTED is ignored.
- Sequential increment wraps: 0xFFFF_FFFC → 0x0000_0000.
- Transfer happens when instr_valid && instr_ready. Pop and push in the same cycle leave the count unchanged.

## Timing
- instr_valid = (count≠0) && !redirect_en. instr and instr_pc come from the registered head entry. instr/instr_pc are 0 when empty.
- Fetch-to-decode latency: a word hit at edge N is visible as head at N+1 if the queue was empty.
- imemaddr changes only at edges. It is held stable while imemREN=1 and !ihit.
- Redirect at edge N: imemaddr=target from N+1, instr_valid=0 until the first post-redirect hit.
- Throughput: 1 word/cycle with single-cycle ihit and continuous instr_ready.

## Structure
- cpu_types_pkg gains:
  - pcsrc_t (PC_SEQ, PC_BR, PC_J, PC_JR)
  - fetch_state_t (FETCH, FULL, HALTED)
  - word_t is reused.
- Sub-module fetch_queue: synchronous FIFO of {pc, instr}.
  - Parameter DEPTH, ports push/pop/flush/full/empty/head.
  - Pointers are log2(DEPTH)+1 bits.
  - Flush clears the pointers only.
- The top holds the FSM, fetch_pc, and target arithmetic.

## Test plan
- Reset with PC_RESET=0x100 → imemREN=1, imemaddr=0x100, instr_valid=0. Then ihit each cycle → head 0x100, 0x104, 0x108 in order.
- instr_ready=0, ihit constant, DEPTH=4 → 4 pushes, then FULL with imemREN=0. One pop → FETCH, addr 0x110.
- Branch redirect: redirect_npc=0x200, imm16=0xFFFE, with ihit in the same cycle → queue empty, hit dropped, next imemaddr=0x1F8.
- Jump/jr:
  - PC_J, redirect_npc=0x9000_0000, jaddr=0x40 → target 0x9000_0100.
  - PC_JR with reg31=0x3C → 0x3C.
  - PCSrc=5 → redirect_npc.
- Wrap: PC_RESET=0xFFFF_FFFC, hit → next imemaddr=0.
- Halt with 2 queued entries → imemREN=0 next cycle, both entries drain. A later redirect is ignored. nRST low restores PC_RESET.
